tanh_maxpool: RTL

TANH_MAXPOOL -- requirements
Module: tanh_maxpool

---
 rtl/tanh_maxpool.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tanh_maxpool.sv
// 2x2 max-pool over a raster stream of paired float32 tanh results.
// Horizontal pairs reduce on arrival; even rows park in a row buffer, odd rows emit pooled values.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// EVEN_ROW | top row of a pooling window: store hmax per column, no output
// ODD_ROW  | bottom row: pool hmax against buffered column, emit result
module tanh_maxpool #(
    parameter int W = 24,
    parameter int H = 24,
    localparam int CW = (W / 2 > 1) ? $clog2(W / 2) : 1,
    localparam int RW = (H / 2 > 1) ? $clog2(H / 2) : 1
) (
    input  logic          clk,
    input  logic          resetExternal,
    input  logic [63:0]   in_data,
    input  logic          in_valid,
    input  logic          clear,
    output logic [31:0]   out_data,
    output logic          out_valid,
    output logic [CW-1:0] out_col,
    output logic [RW-1:0] out_row,
    output logic          frame_done
);

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    localparam logic [CW-1:0] COL_LAST  = CW'(W / 2 - 1);
    localparam logic [RW-1:0] PAIR_LAST = RW'(H / 2 - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] pair_q, pair_d;
    logic [31:0]   row_buf [W/2];
    logic [1:0]    rst_sync;
    logic          rst_b;
    logic          accept;
    logic          col_last;
    logic          pair_last;
    logic          pool_fire;
    logic [31:0]   hmax;
    logic [31:0]   pooled;

    // Bit-level float max: sign first, then magnitude; ties keep the left operand.
    function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = a;
        if (a[31] != b[31]) begin
            r = a[31] ? b : a;
        end else if (!a[31]) begin
            r = (b[30:0] > a[30:0]) ? b : a;
        end else begin
            r = (b[30:0] < a[30:0]) ? b : a;
        end
        return r;
    endfunction

    // Assert immediately, release two edges later so a word never lands on the release edge.
    always_ff @(posedge clk or negedge resetExternal) begin
        if (!resetExternal) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_b = rst_sync[1];

    assign accept    = in_valid && !clear;
    assign col_last  = (col_q == COL_LAST);
    assign pair_last = (pair_q == PAIR_LAST);
    assign hmax      = fmax(in_data[63:32], in_data[31:0]);
    assign pooled    = fmax(row_buf[col_q], hmax);
    assign pool_fire = accept && (state_q == ODD_ROW);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        pair_d  = pair_q;
        if (clear) begin
            state_d = EVEN_ROW;
            col_d   = '0;
            pair_d  = '0;
        end else if (in_valid) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                if (state_q == EVEN_ROW) begin
                    state_d = ODD_ROW;
                end else begin
                    state_d = EVEN_ROW;
                    pair_d  = pair_last ? '0 : pair_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= EVEN_ROW;
            col_q   <= '0;
            pair_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            pair_q  <= pair_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < W / 2; i++) begin
                row_buf[i] <= '0;
            end
        end else if (accept && (state_q == EVEN_ROW)) begin
            row_buf[col_q] <= hmax;
        end
    end

    // Data, column and row hold between pulses; only the qualifiers are single-cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= pool_fire;
            frame_done <= pool_fire && col_last && pair_last;
            if (pool_fire) begin
                out_data <= pooled;
                out_col  <= col_q;
                out_row  <= pair_q;
            end
        end
    end

endmodule
